// File: rtl/game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl
//   Game sequencer between the VGA timing and the game-render datapath.
//   Debounces the start button, derives a once-per-frame tick from vSync,
//   runs the TITLE/PLAY/DYING/OVER/WIN state machine, owns lives and the
//   level countdown, gates motion in the render block and selects the value
//   shown on the 7-segment counter.
//
// Ports
//   ClkPort    in   1   system clock
//   Reset      in   1   synchronous active-high reset
//   vSync      in   1   VGA vertical sync, active-low, ClkPort domain
//   btn_start  in   1   raw start/jump button level
//   hit        in   1   1-cycle pulse: player killed
//   goal       in   1   1-cycle pulse: flag reached
//   score      in  16   current score from the render block
//   frame_tick out  1   1-cycle pulse per vSync falling edge
//   game_run   out  1   high only in PLAY (render block freezes when low)
//   respawn    out  1   1-cycle pulse: return player to start position
//   state      out  3   0 TITLE, 1 PLAY, 2 DYING, 3 OVER, 4 WIN
//   lives      out  3   remaining lives
//   time_left  out 10   remaining seconds
//   disp_num   out 16   value for the 7-segment counter
// ---------------------------------------------------------------------------
module game_flow_ctrl #(
   parameter int CLK_HZ          = 100_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LIVES_INIT      = 3,
   parameter int TIME_INIT       = 300,
   parameter int DEATH_FRAMES    = 120
) (
   input  logic        ClkPort,
   input  logic        Reset,
   input  logic        vSync,
   input  logic        btn_start,
   input  logic        hit,
   input  logic        goal,
   input  logic [15:0] score,
   output logic        frame_tick,
   output logic        game_run,
   output logic        respawn,
   output logic [2:0]  state,
   output logic [2:0]  lives,
   output logic [9:0]  time_left,
   output logic [15:0] disp_num
);

   localparam logic [2:0] S_TITLE = 3'd0;
   localparam logic [2:0] S_PLAY  = 3'd1;
   localparam logic [2:0] S_DYING = 3'd2;
   localparam logic [2:0] S_OVER  = 3'd3;
   localparam logic [2:0] S_WIN   = 3'd4;

   // +1 keeps every counter at least one bit wide even for parameter value 1
   localparam int SEC_W = $clog2(CLK_HZ + 1);
   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DF_W  = $clog2(DEATH_FRAMES + 1);

   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DF_W-1:0]  DF_LAST  = DF_W'(DEATH_FRAMES - 1);
   localparam logic [2:0]       LIVES_V  = 3'(LIVES_INIT);
   localparam logic [9:0]       TIME_V   = 10'(TIME_INIT);

   // ---------------- start button debounce ----------------
   logic [DB_W-1:0] db_cnt_reg;
   logic            db_level_reg;
   logic            db_prev_reg;
   logic            start_pulse_reg;

   always_ff @(posedge ClkPort) begin
      if (Reset) begin
         db_cnt_reg      <= '0;
         db_level_reg    <= 1'b0;
         db_prev_reg     <= 1'b0;
         start_pulse_reg <= 1'b0;
      end else begin
         db_prev_reg     <= db_level_reg;
         start_pulse_reg <= db_level_reg & ~db_prev_reg;
         if (btn_start != db_level_reg) begin
            // counter holds the number of earlier differing cycles, so the
            // level is taken on the DEBOUNCE_CYCLES-th consecutive one
            if (db_cnt_reg == DB_LAST) begin
               db_level_reg <= btn_start;
               db_cnt_reg   <= '0;
            end else begin
               db_cnt_reg   <= db_cnt_reg + 1'b1;
            end
         end else begin
            db_cnt_reg <= '0;
         end
      end
   end

   // ---------------- frame tick ----------------
   logic vs_prev_reg;
   logic frame_tick_reg;

   always_ff @(posedge ClkPort) begin
      if (Reset) begin
         vs_prev_reg    <= 1'b0;
         frame_tick_reg <= 1'b0;
      end else begin
         vs_prev_reg    <= vSync;
         frame_tick_reg <= vs_prev_reg & ~vSync;
      end
   end

   // ---------------- game state machine ----------------
   logic [2:0]       state_reg,   state_next;
   logic [2:0]       lives_reg,   lives_next;
   logic [9:0]       time_reg,    time_next;
   logic [SEC_W-1:0] sec_reg,     sec_next;
   logic [DF_W-1:0]  dfr_reg,     dfr_next;
   logic             respawn_reg, respawn_next;
   logic [15:0]      disp_reg,    disp_next;
   logic             sec_wrap;

   assign sec_wrap = (sec_reg == SEC_LAST);

   always_comb begin
      state_next   = state_reg;
      lives_next   = lives_reg;
      time_next    = time_reg;
      sec_next     = sec_reg;
      dfr_next     = dfr_reg;
      respawn_next = 1'b0;
      case (state_reg)
         S_TITLE: begin
            if (start_pulse_reg) begin
               state_next   = S_PLAY;
               time_next    = TIME_V;
               sec_next     = '0;
               respawn_next = 1'b1;
            end
         end
         S_PLAY: begin
            sec_next = sec_wrap ? '0 : sec_reg + 1'b1;
            if (sec_wrap && (time_reg != 10'd0))
               time_next = time_reg - 10'd1;
            // goal outranks a hit in the same cycle
            if (goal) begin
               state_next = S_WIN;
            end else if (hit || (sec_wrap && (time_reg == 10'd1))) begin
               state_next = S_DYING;
               dfr_next   = '0;
            end
         end
         S_DYING: begin
            if (frame_tick_reg) begin
               if (dfr_reg == DF_LAST) begin
                  lives_next = lives_reg - 3'd1;
                  if (lives_reg == 3'd1) begin
                     state_next = S_OVER;
                  end else begin
                     state_next   = S_PLAY;
                     time_next    = TIME_V;
                     respawn_next = 1'b1;
                  end
               end else begin
                  dfr_next = dfr_reg + 1'b1;
               end
            end
         end
         S_OVER, S_WIN: begin
            if (start_pulse_reg) begin
               state_next = S_TITLE;
               lives_next = LIVES_V;
               time_next  = TIME_V;
            end
         end
         default: state_next = S_TITLE;
      endcase
   end

   always_comb begin
      disp_next = 16'd0;
      case (state_reg)
         S_PLAY, S_OVER, S_WIN: disp_next = score;
         S_DYING:               disp_next = {13'b0, lives_reg};
         default:               disp_next = 16'd0;
      endcase
   end

   always_ff @(posedge ClkPort) begin
      if (Reset) begin
         state_reg   <= S_TITLE;
         lives_reg   <= LIVES_V;
         time_reg    <= TIME_V;
         sec_reg     <= '0;
         dfr_reg     <= '0;
         respawn_reg <= 1'b0;
         disp_reg    <= 16'd0;
      end else begin
         state_reg   <= state_next;
         lives_reg   <= lives_next;
         time_reg    <= time_next;
         sec_reg     <= sec_next;
         dfr_reg     <= dfr_next;
         respawn_reg <= respawn_next;
         disp_reg    <= disp_next;
      end
   end

   assign frame_tick = frame_tick_reg;
   assign game_run   = (state_reg == S_PLAY);
   assign respawn    = respawn_reg;
   assign state      = state_reg;
   assign lives      = lives_reg;
   assign time_left  = time_reg;
   assign disp_num   = disp_reg;

endmodule
